// File: rtl/hazard_stall_unit_if.sv
// Bundle between the ID/EX pipeline stage and the hazard stall unit.
// The pipeline side is the master, the stall unit is the slave.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs1_addr;
  logic [4:0]       ID_rs2_addr;
  logic             ID_uses_rs2;
  logic             EX_MemRead;
  logic [4:0]       EX_rd_addr;
  logic             EX_is_mul;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Write;
  logic             NoOp;
  logic             EXMEM_Bubble;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ID_rs1_addr, ID_rs2_addr, ID_uses_rs2, EX_MemRead, EX_rd_addr, EX_is_mul,
    input  PC_Write, IFID_Write, IDEX_Write, NoOp, EXMEM_Bubble, mul_busy, stall_count
  );

  modport slave (
    input  ID_rs1_addr, ID_rs2_addr, ID_uses_rs2, EX_MemRead, EX_rd_addr, EX_is_mul,
    output PC_Write, IFID_Write, IDEX_Write, NoOp, EXMEM_Bubble, mul_busy, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Detects load-use and multi-cycle multiply hazards that forwarding cannot cover,
// and drives the front-end stall / bubble controls plus a saturating stall counter.
module hazard_stall_unit #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  hazard_stall_unit_if.slave  bus
);

  typedef enum logic {
    RUN,
    MUL_BUSY
  } state_t;

  localparam logic [3:0]       MCNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [3:0]       mcnt;
  logic [3:0]       mcnt_next;
  logic [CNT_W-1:0] stall_count;
  logic             load_use;
  logic             mul_start;
  logic             mul_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      mcnt  <= 4'd0;
    end else begin
      state <= state_next;
      mcnt  <= mcnt_next;
    end
  end

  // A multiply takes precedence over a load-use hazard on the same EX instruction.
  always_comb begin
    load_use = bus.EX_MemRead && (bus.EX_rd_addr != 5'd0) &&
               ((bus.EX_rd_addr == bus.ID_rs1_addr) ||
                (bus.ID_uses_rs2 && (bus.EX_rd_addr == bus.ID_rs2_addr)));
    mul_start = (state == RUN) && bus.EX_is_mul && (MUL_LAT > 1);
    mul_stall = mul_start || ((state == MUL_BUSY) && (mcnt != 4'd0));

    state_next       = state;
    mcnt_next        = mcnt;
    bus.PC_Write     = 1'b1;
    bus.IFID_Write   = 1'b1;
    bus.IDEX_Write   = 1'b1;
    bus.NoOp         = 1'b0;
    bus.EXMEM_Bubble = 1'b0;
    bus.mul_busy     = 1'b0;

    if (!rst_i) begin
      if (mul_stall) begin
        bus.PC_Write     = 1'b0;
        bus.IFID_Write   = 1'b0;
        bus.IDEX_Write   = 1'b0;
        bus.EXMEM_Bubble = 1'b1;
        bus.mul_busy     = 1'b1;
      end else if (load_use) begin
        bus.PC_Write   = 1'b0;
        bus.IFID_Write = 1'b0;
        bus.NoOp       = 1'b1;
      end
    end

    case (state)
      RUN: begin
        if (mul_start) begin
          state_next = MUL_BUSY;
          mcnt_next  = MCNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (mcnt != 4'd0) begin
          mcnt_next = mcnt - 4'd1;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        mcnt_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count <= '0;
    end else if (!bus.PC_Write && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit; a behavioural model feeds
// a scoreboard queue that an independent monitor drains every cycle.
module tb_hazard_stall_unit;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 6;
  localparam logic [5:0] EXP_RUN  = 6'b111000;
  localparam logic [5:0] EXP_MUL  = 6'b000011;
  localparam logic [5:0] EXP_LOAD = 6'b001100;

  typedef struct {
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference model state: cycles the current multiply still holds EX, and stall total.
  int   mul_left = 0;
  int   model_cnt = 0;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic uses2, input logic memrd, input logic [4:0] rd,
                               input logic is_mul);
    exp_t e;
    logic lu;
    @(posedge clk_i);
    #1;
    rst_i               = rst;
    bus.ID_rs1_addr     = rs1;
    bus.ID_rs2_addr     = rs2;
    bus.ID_uses_rs2     = uses2;
    bus.EX_MemRead      = memrd;
    bus.EX_rd_addr      = rd;
    bus.EX_is_mul       = is_mul;
    lu = memrd && (rd != 0) && (rd == rs1 || (uses2 && rd == rs2));
    e.cnt  = CNT_W'(model_cnt);
    e.ctrl = EXP_RUN;
    if (rst) begin
      mul_left = 0;
    end else if (mul_left > 1) begin
      e.ctrl = EXP_MUL;
      mul_left--;
    end else if (mul_left == 1) begin
      mul_left = 0;
      if (lu) e.ctrl = EXP_LOAD;
    end else if (is_mul && MUL_LAT > 1) begin
      e.ctrl = EXP_MUL;
      mul_left = MUL_LAT - 1;
    end else if (lu) begin
      e.ctrl = EXP_LOAD;
    end
    sb.push_back(e);
    if (rst) model_cnt = 0;
    else if (e.ctrl[5] == 1'b0 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] act;
    act = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.NoOp, bus.EXMEM_Bubble, bus.mul_busy};
    total++;
    if (act !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
    end
    total++;
    if (bus.stall_count !== e.cnt) begin
      bad++;
      $display("[TB] FAIL stall_count t=%0t got=%0d want=%0d", $time, bus.stall_count, e.cnt);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    rst_i = 1'b1;
    bus.ID_rs1_addr = '0;
    bus.ID_rs2_addr = '0;
    bus.ID_uses_rs2 = 1'b0;
    bus.EX_MemRead  = 1'b0;
    bus.EX_rd_addr  = '0;
    bus.EX_is_mul   = 1'b0;
    repeat (2) @(posedge clk_i);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    // load-use on rs1, then load gone
    applyStimulus(0, 5, 0, 0, 1, 5, 0);
    applyStimulus(0, 5, 0, 0, 0, 5, 0);
    // x0 and rs2 usage cases
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 7, 0, 1, 7, 0);
    applyStimulus(0, 1, 7, 1, 1, 7, 0);
    applyStimulus(0, 1, 7, 1, 0, 7, 0);
    // single multiply
    repeat (4) applyStimulus(0, 1, 2, 1, 0, 9, 1);
    applyStimulus(0, 1, 2, 1, 0, 9, 0);
    // back-to-back multiplies
    repeat (8) applyStimulus(0, 1, 2, 1, 0, 9, 1);
    applyStimulus(0, 1, 2, 1, 0, 9, 0);
    // load + multiply conflict
    repeat (4) applyStimulus(0, 3, 0, 0, 1, 3, 1);
    applyStimulus(0, 3, 0, 0, 0, 3, 0);
    // reset during the second multiply stall cycle, then a fresh multiply
    applyStimulus(0, 1, 2, 0, 0, 4, 1);
    applyStimulus(0, 1, 2, 0, 0, 4, 1);
    applyStimulus(1, 1, 2, 0, 0, 4, 1);
    repeat (5) applyStimulus(0, 1, 2, 0, 0, 4, 1);
    applyStimulus(0, 1, 2, 0, 0, 4, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
    end

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
